binary_div_seq: RTL and testbench



---
 rtl/binary_div_seq_if.sv | 22 ++
 rtl/binary_div_seq.sv | 127 ++++++++++++
 tb/tb_binary_div_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/binary_div_seq_if.sv
// Start/done handshake and operand/result bundle for binary_div_seq.
// The dz member exists only when DIV_ZERO_FLAG_EN is defined.
interface binary_div_seq_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
`ifdef DIV_ZERO_FLAG_EN
    logic             dz;

    modport master (output start, a, b, input busy, done, q, r, dz);
    modport slave  (input start, a, b, output busy, done, q, r, dz);
`else
    modport master (output start, a, b, input busy, done, q, r);
    modport slave  (input start, a, b, output busy, done, q, r);
`endif
endinterface

// File: rtl/binary_div_seq.sv
// Sequential unsigned restoring divider, one quotient bit per clock (optional dz flag: DIV_ZERO_FLAG_EN).
// Latency: done pulses WIDTH+1 cycles after the edge that accepts start; results held until the next done.
// Backpressure: none; start is sampled only in IDLE and ignored while RUN/DONE, with no queuing.
module binary_div_seq #(
    parameter int WIDTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    binary_div_seq_if.slave div_if
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
`ifdef DIV_ZERO_FLAG_EN
    logic             dz_work_q, dz_work_d;
    logic             dz_q, dz_d;
`endif

    // Subtract by adding the one's complement with carry-in; diff MSB set means borrow.
    assign partial = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = partial + ~{1'b0, dvs_q} + (WIDTH+1)'(1);

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        q_d     = q_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_work_d = dz_work_q;
        dz_d      = dz_q;
`endif
        case (state_q)
            IDLE: begin
                if (div_if.start) begin
                    dvd_d   = div_if.a;
                    dvs_d   = div_if.b;
                    rem_d   = '0;
                    cnt_d   = '0;
`ifdef DIV_ZERO_FLAG_EN
                    dz_work_d = (div_if.b == '0);
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == CW'(WIDTH)) begin
                    // All bits produced: publish the working registers.
                    q_d     = dvd_q;
                    r_d     = rem_q;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d    = dz_work_q;
`endif
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!diff[WIDTH]) begin
                        rem_d = diff[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = partial[WIDTH-1:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz_work_q <= 1'b0;
            dz_q      <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_work_q <= dz_work_d;
            dz_q      <= dz_d;
`endif
        end
    end

    assign div_if.busy = (state_q == RUN);
    assign div_if.done = (state_q == DONE);
    assign div_if.q    = q_q;
    assign div_if.r    = r_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_if.dz   = dz_q;
`endif

endmodule

// File: tb/tb_binary_div_seq.sv
// Bench for binary_div_seq (WIDTH=4): scoreboard of expected results checked at each done pulse.
module tb_binary_div_seq;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    exp_t exp_q[$];

    binary_div_seq_if #(.WIDTH(W)) dif ();

    binary_div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .div_if(dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h want=%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == 0) begin
            e.q = '1;
            e.r = a;
        end else begin
            e.q = W'(int'(a) / int'(b));
            e.r = W'(int'(a) % int'(b));
        end
        e.dz = (b == 0);
        return e;
    endfunction

    // Result monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && dif.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("q", 32'(dif.q), 32'(e.q));
                chk("r", 32'(dif.r), 32'(e.r));
`ifdef DIV_ZERO_FLAG_EN
                chk("dz", 32'(dif.dz), 32'(e.dz));
`endif
            end
        end
    end

    // Called at a negedge; drives start until it is seen accepted (busy high).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
        int n;
        dif.start = 1'b1;
        dif.a     = a;
        dif.b     = b;
        exp_q.push_back(model(a, b));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dif.busy && n < 10);
        if (!dif.busy) chk("accept_timeout", 32'd0, 32'd1);
        if (!hold) dif.start = 1'b0;
    endtask

    // Called at the first negedge with busy high; returns at the negedge showing done.
    task automatic wait_done();
        int n;
        n = 1;
        forever begin
            @(negedge clk);
            if (!dif.busy || n >= 30) break;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'(W + 1));
        chk("done_after_busy", 32'(dif.done), 32'd1);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        dif.start = 1'b0;
        dif.a     = '0;
        dif.b     = '0;
        #1;
        chk("rst_busy", 32'(dif.busy), 32'd0);
        chk("rst_done", 32'(dif.done), 32'd0);
        chk("rst_q", 32'(dif.q), 32'd0);
        chk("rst_r", 32'(dif.r), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("rst_dz", 32'(dif.dz), 32'd0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(4'd13, 4'd3, 1'b0);
        wait_done();
        issue(4'd15, 4'd1, 1'b0);
        wait_done();
        issue(4'd5, 4'd7, 1'b0);
        wait_done();
        issue(4'd9, 4'd0, 1'b0);
        wait_done();
        issue(4'd8, 4'd2, 1'b0);
        wait_done();

        // start held through RUN with changed operands must not disturb the running division
        issue(4'd12, 4'd5, 1'b1);
        dif.a = 4'd1;
        dif.b = 4'd1;
        exp_q.push_back(model(4'd1, 4'd1));
        wait_done();
        begin
            int n;
            n = 0;
            while (!dif.busy && n < 10) begin
                @(negedge clk);
                n++;
            end
            chk("held_start_accept", 32'(dif.busy), 32'd1);
        end
        dif.start = 1'b0;
        wait_done();

        // Reset two cycles into a division: everything clears, no done for it
        issue(4'd11, 4'd3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(dif.busy), 32'd0);
        chk("abort_done", 32'(dif.done), 32'd0);
        chk("abort_q", 32'(dif.q), 32'd0);
        chk("abort_r", 32'(dif.r), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
        chk("abort_dz", 32'(dif.dz), 32'd0);
`endif
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(dif.done), 32'd0);
        end
        issue(4'd14, 4'd4, 1'b0);
        wait_done();

        // Exhaustive sweep
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ab;
            ab = 8'(i);
            issue(ab[7:4], ab[3:0], 1'b0);
            wait_done();
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
